// File: rtl/sys_tx_ctrl_pkg.sv
// Shared configuration for the system-controller transmit path:
// data widths and the 3-bit state encoding of the TX sequencer.
package sys_tx_ctrl_pkg;

  localparam int WIDTH         = 8;
  localparam int ALU_OUT_WIDTH = 2 * WIDTH;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RF_SEND = 3'd1;
  localparam logic [2:0] ST_RF_WAIT = 3'd2;
  localparam logic [2:0] ST_LO_SEND = 3'd3;
  localparam logic [2:0] ST_LO_WAIT = 3'd4;
  localparam logic [2:0] ST_HI_SEND = 3'd5;
  localparam logic [2:0] ST_HI_WAIT = 3'd6;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RF_SEND = ST_RF_SEND,
    RF_WAIT = ST_RF_WAIT,
    LO_SEND = ST_LO_SEND,
    LO_WAIT = ST_LO_WAIT,
    HI_SEND = ST_HI_SEND,
    HI_WAIT = ST_HI_WAIT
  } tx_state_e;

endpackage

// File: rtl/sys_tx_ctrl_pend_slot.sv
// One-deep pending slot: holding register, pending flag and drop detection
// for one response source of the TX sequencer.
module sys_tx_pend_slot
  import sys_tx_ctrl_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid,
  input  logic [W-1:0] data,
  input  logic         in_flight,
  input  logic         take,
  output logic         pend_r,
  output logic [W-1:0] hold_r,
  output logic         drop_r
);

  logic accept_s;

  // A new response is only accepted into an empty slot whose previous frame has left
  always_comb begin
    accept_s = 1'b0;
    if (valid && !pend_r && !in_flight) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Slot state: held data is never overwritten while pending or in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_r <= 1'b0;
      hold_r <= '0;
      drop_r <= 1'b0;
    end else begin
      drop_r <= valid & ~accept_s;
      if (accept_s) begin
        hold_r <= data;
        pend_r <= 1'b1;
      end else if (take) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

endmodule

// File: rtl/sys_tx_ctrl.sv
// Transmit-side sequencer: serialises register-file bytes and 2-byte ALU
// results (low byte first) into the UART TX using its busy handshake.
module sys_tx_ctrl
  import sys_tx_ctrl_pkg::*;
#(
  parameter int WIDTH         = sys_tx_ctrl_pkg::WIDTH,
  parameter int ALU_OUT_WIDTH = sys_tx_ctrl_pkg::ALU_OUT_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         RF_RdData,
  input  logic                     RF_RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_Valid,
  input  logic                     TX_Busy,
  output logic [WIDTH-1:0]         TX_P_DATA,
  output logic                     TX_D_VALID,
  output logic                     Ctrl_Busy,
  output logic                     Drop_Err
);

  tx_state_e                state_r;
  logic [WIDTH-1:0]         tx_data_r;
  logic                     tx_valid_r;
  logic                     seen_low_r;
  logic                     ctrl_busy_r;
  logic                     rf_pend_r, alu_pend_r;
  logic                     rf_drop_r, alu_drop_r;
  logic [WIDTH-1:0]         rf_hold_r;
  logic [ALU_OUT_WIDTH-1:0] alu_hold_r;
  logic                     rf_flight_s, alu_flight_s;
  logic                     rf_take_s, alu_take_s;

  sys_tx_pend_slot #(.W(WIDTH)) u_rf_slot (
    .CLK(CLK), .RST(RST), .valid(RF_RdData_Valid), .data(RF_RdData),
    .in_flight(rf_flight_s), .take(rf_take_s),
    .pend_r(rf_pend_r), .hold_r(rf_hold_r), .drop_r(rf_drop_r)
  );

  sys_tx_pend_slot #(.W(ALU_OUT_WIDTH)) u_alu_slot (
    .CLK(CLK), .RST(RST), .valid(ALU_OUT_Valid), .data(ALU_OUT),
    .in_flight(alu_flight_s), .take(alu_take_s),
    .pend_r(alu_pend_r), .hold_r(alu_hold_r), .drop_r(alu_drop_r)
  );

  // Which source owns the frame in flight, and which one IDLE picks (RF first)
  always_comb begin
    rf_flight_s  = 1'b0;
    alu_flight_s = 1'b0;
    rf_take_s    = 1'b0;
    alu_take_s   = 1'b0;
    case (state_r)
      IDLE: begin
        rf_take_s  = rf_pend_r;
        alu_take_s = alu_pend_r & ~rf_pend_r;
      end
      RF_SEND, RF_WAIT:                   rf_flight_s  = 1'b1;
      LO_SEND, LO_WAIT, HI_SEND, HI_WAIT: alu_flight_s = 1'b1;
      default: begin
        rf_flight_s  = 1'b0;
        alu_flight_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered frame data, request and busy outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      seen_low_r  <= 1'b0;
      ctrl_busy_r <= 1'b0;
    end else begin
      ctrl_busy_r <= (state_r != IDLE) | rf_pend_r | alu_pend_r;
      case (state_r)
        IDLE: begin
          // seen_low_r guards against a busy level left over from an earlier frame
          if (rf_pend_r) begin
            state_r    <= RF_SEND;
            tx_data_r  <= rf_hold_r;
            tx_valid_r <= 1'b1;
            seen_low_r <= ~TX_Busy;
          end else if (alu_pend_r) begin
            state_r    <= LO_SEND;
            tx_data_r  <= alu_hold_r[WIDTH-1:0];
            tx_valid_r <= 1'b1;
            seen_low_r <= ~TX_Busy;
          end else begin
            tx_valid_r <= 1'b0;
          end
        end
        RF_SEND, LO_SEND, HI_SEND: begin
          if (TX_Busy && seen_low_r) begin
            tx_valid_r <= 1'b0;
            state_r    <= (state_r == RF_SEND) ? RF_WAIT :
                          (state_r == LO_SEND) ? LO_WAIT : HI_WAIT;
          end else if (!TX_Busy) begin
            seen_low_r <= 1'b1;
          end else begin
            seen_low_r <= seen_low_r;
          end
        end
        LO_WAIT: begin
          if (!TX_Busy) begin
            state_r    <= HI_SEND;
            tx_data_r  <= alu_hold_r[ALU_OUT_WIDTH-1:WIDTH];
            tx_valid_r <= 1'b1;
            seen_low_r <= 1'b1;
          end else begin
            state_r <= LO_WAIT;
          end
        end
        RF_WAIT, HI_WAIT: begin
          if (!TX_Busy) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign TX_P_DATA  = tx_data_r;
  assign TX_D_VALID = tx_valid_r;
  assign Ctrl_Busy  = ctrl_busy_r;
  assign Drop_Err   = rf_drop_r | alu_drop_r;

endmodule

// File: tb/tb_sys_tx_ctrl.sv
// Directed self-checking bench for sys_tx_ctrl with a reactive UART TX model.
module tb_sys_tx_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic        TX_Busy;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VALID;
  logic        Ctrl_Busy;
  logic        Drop_Err;

  int errors = 0;
  int checks = 0;

  logic       uart_auto = 1'b0;
  logic       man_busy  = 1'b0;
  logic       uart_busy = 1'b0;
  int         busy_len  = 6;
  logic [7:0] frames[$];
  int         drop_cnt   = 0;
  int         rise_cnt   = 0;
  logic       prev_valid = 1'b0;

  assign TX_Busy = uart_auto ? uart_busy : man_busy;

  sys_tx_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .TX_Busy(TX_Busy),
    .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID),
    .Ctrl_Busy(Ctrl_Busy), .Drop_Err(Drop_Err)
  );

  always #5 CLK = ~CLK;

  // UART TX model: accepts a request, then stays busy for busy_len cycles
  initial begin
    forever begin
      @(negedge CLK);
      if (uart_auto && TX_D_VALID && !uart_busy) begin
        frames.push_back(TX_P_DATA);
        @(posedge CLK);
        #1 uart_busy = 1'b1;
        repeat (busy_len) @(posedge CLK);
        #1 uart_busy = 1'b0;
      end
    end
  end

  // Drop pulses, and new requests raised while the UART is still busy
  always @(negedge CLK) begin
    if (Drop_Err) drop_cnt <= drop_cnt + 1;
    if (uart_auto && TX_D_VALID && !prev_valid && TX_Busy) rise_cnt <= rise_cnt + 1;
    prev_valid <= TX_D_VALID;
  end

  task automatic pulse_rf(input logic [7:0] d);
    @(posedge CLK);
    #1 RF_RdData = d; RF_RdData_Valid = 1'b1;
    @(posedge CLK);
    #1 RF_RdData_Valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    @(posedge CLK);
    #1 ALU_OUT = d; ALU_OUT_Valid = 1'b1;
    @(posedge CLK);
    #1 ALU_OUT_Valid = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!Ctrl_Busy && !TX_Busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RF_RdData = 8'h00; RF_RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000; ALU_OUT_Valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (TX_D_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", TX_D_VALID); end
    checks++; if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", TX_P_DATA); end
    checks++; if (Ctrl_Busy !== 1'b0) begin errors++; $display("FAIL reset_ctrl_busy got=%b exp=0", Ctrl_Busy); end
    checks++; if (Drop_Err !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", Drop_Err); end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_single_rf();
    int  vcnt = 0;
    logic busy_at_fall;
    logic ok = 1'b0;
    uart_auto = 1'b0; man_busy = 1'b0;
    pulse_rf(8'h5A);
    checks++; if (TX_D_VALID !== 1'b0) begin errors++; $display("FAIL rf_latency_early got=%b exp=0", TX_D_VALID); end
    @(posedge CLK); #1;
    checks++; if (TX_D_VALID !== 1'b1) begin errors++; $display("FAIL rf_latency got=%b exp=1", TX_D_VALID); end
    checks++; if (TX_P_DATA !== 8'h5A) begin errors++; $display("FAIL rf_data got=%h exp=5a", TX_P_DATA); end
    @(negedge CLK); if (TX_D_VALID) vcnt++;
    @(posedge CLK);
    @(negedge CLK); if (TX_D_VALID) vcnt++;
    @(posedge CLK);
    #1 man_busy = 1'b1;
    repeat (10) begin
      @(negedge CLK); if (TX_D_VALID) vcnt++;
      @(posedge CLK);
    end
    busy_at_fall = Ctrl_Busy;
    #1 man_busy = 1'b0;
    checks++; if (vcnt !== 3) begin errors++; $display("FAIL rf_valid_cycles got=%0d exp=3", vcnt); end
    checks++; if (busy_at_fall !== 1'b1) begin errors++; $display("FAIL rf_ctrl_busy_held got=%b exp=1", busy_at_fall); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rf_idle_timeout got=%b exp=1", ok); end
  endtask

  task automatic test_alu_order();
    int base = frames.size();
    int rbase = rise_cnt;
    logic ok = 1'b0;
    uart_auto = 1'b1; busy_len = 6;
    pulse_alu(16'h1234);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL alu_idle_timeout got=%b exp=1", ok); end
    checks++; if (frames.size() - base !== 2) begin errors++; $display("FAIL alu_frame_count got=%0d exp=2", frames.size() - base); end
    checks++; if (frames[base] !== 8'h34) begin errors++; $display("FAIL alu_lo got=%h exp=34", frames[base]); end
    checks++; if (frames[base+1] !== 8'h12) begin errors++; $display("FAIL alu_hi got=%h exp=12", frames[base+1]); end
    checks++; if (rise_cnt - rbase !== 0) begin errors++; $display("FAIL alu_req_while_busy got=%0d exp=0", rise_cnt - rbase); end
  endtask

  task automatic test_same_cycle();
    int base = frames.size();
    int dbase = drop_cnt;
    logic ok = 1'b0;
    @(posedge CLK);
    #1 RF_RdData = 8'hAB; RF_RdData_Valid = 1'b1; ALU_OUT = 16'hBEEF; ALU_OUT_Valid = 1'b1;
    @(posedge CLK);
    #1 RF_RdData_Valid = 1'b0; ALU_OUT_Valid = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL both_idle_timeout got=%b exp=1", ok); end
    checks++; if (frames.size() - base !== 3) begin errors++; $display("FAIL both_count got=%0d exp=3", frames.size() - base); end
    checks++; if (frames[base] !== 8'hAB) begin errors++; $display("FAIL both_f0 got=%h exp=ab", frames[base]); end
    checks++; if (frames[base+1] !== 8'hEF) begin errors++; $display("FAIL both_f1 got=%h exp=ef", frames[base+1]); end
    checks++; if (frames[base+2] !== 8'hBE) begin errors++; $display("FAIL both_f2 got=%h exp=be", frames[base+2]); end
    checks++; if (drop_cnt - dbase !== 0) begin errors++; $display("FAIL both_drops got=%0d exp=0", drop_cnt - dbase); end
  endtask

  task automatic test_back_to_back();
    int base = frames.size();
    int dbase;
    logic ok = 1'b0;
    busy_len = 10;
    pulse_alu(16'h1234);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (frames.size() - base >= 1) break;
    end
    @(posedge CLK);
    dbase = drop_cnt;
    pulse_rf(8'h01);
    checks++; if (Drop_Err !== 1'b0) begin errors++; $display("FAIL b2b_first_drop got=%b exp=0", Drop_Err); end
    repeat (2) @(posedge CLK);
    pulse_rf(8'h02);
    checks++; if (Drop_Err !== 1'b1) begin errors++; $display("FAIL b2b_second_drop got=%b exp=1", Drop_Err); end
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_idle_timeout got=%b exp=1", ok); end
    checks++; if (frames.size() - base !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", frames.size() - base); end
    checks++; if (frames[base] !== 8'h34) begin errors++; $display("FAIL b2b_f0 got=%h exp=34", frames[base]); end
    checks++; if (frames[base+1] !== 8'h12) begin errors++; $display("FAIL b2b_f1 got=%h exp=12", frames[base+1]); end
    checks++; if (frames[base+2] !== 8'h01) begin errors++; $display("FAIL b2b_f2 got=%h exp=01", frames[base+2]); end
    checks++; if (drop_cnt - dbase !== 1) begin errors++; $display("FAIL b2b_drop_pulses got=%0d exp=1", drop_cnt - dbase); end
  endtask

  task automatic test_busy_high_entry();
    logic ok = 1'b0;
    uart_auto = 1'b0; man_busy = 1'b1;
    pulse_rf(8'h3C);
    @(posedge CLK); #1;
    checks++; if (TX_D_VALID !== 1'b1) begin errors++; $display("FAIL bh_request got=%b exp=1", TX_D_VALID); end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (TX_D_VALID !== 1'b1) begin errors++; $display("FAIL bh_held_high got=%b exp=1", TX_D_VALID); end
    man_busy = 1'b0;
    @(posedge CLK); #1;
    checks++; if (TX_D_VALID !== 1'b1) begin errors++; $display("FAIL bh_after_low got=%b exp=1", TX_D_VALID); end
    man_busy = 1'b1;
    @(posedge CLK); #1;
    checks++; if (TX_D_VALID !== 1'b0) begin errors++; $display("FAIL bh_accepted got=%b exp=0", TX_D_VALID); end
    checks++; if (TX_P_DATA !== 8'h3C) begin errors++; $display("FAIL bh_data got=%h exp=3c", TX_P_DATA); end
    repeat (2) @(posedge CLK);
    #1 man_busy = 1'b0;
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bh_idle_timeout got=%b exp=1", ok); end
  endtask

  task automatic test_reset_mid();
    int base;
    logic ok = 1'b0;
    uart_auto = 1'b1; busy_len = 10;
    base = frames.size();
    pulse_alu(16'hCAFE);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (frames.size() - base >= 1) break;
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    checks++; if (TX_D_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", TX_D_VALID); end
    checks++; if (Ctrl_Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", Ctrl_Busy); end
    checks++; if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", TX_P_DATA); end
    @(posedge CLK);
    #1 RST = 1'b1;
    wait_idle(ok);
    base = frames.size();
    pulse_rf(8'h77);
    wait_idle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_idle_timeout got=%b exp=1", ok); end
    checks++; if (frames.size() - base !== 1) begin errors++; $display("FAIL rst_count got=%0d exp=1", frames.size() - base); end
    checks++; if (frames[base] !== 8'h77) begin errors++; $display("FAIL rst_frame got=%h exp=77", frames[base]); end
  endtask

  initial begin
    test_reset();
    test_single_rf();
    test_alu_order();
    test_same_cycle();
    test_back_to_back();
    test_busy_high_entry();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
